// File: rtl/univ_shift_reg.sv
// Universal shift register: eight single-cycle modes plus a counted burst engine.
// Define SHREG_ROTATE_EN to enable the rotate modes (100/101); otherwise they decode as hold.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i,
  input  logic [2:0]       s,
  input  logic             sl_in,
  input  logic             sr_in,
  input  logic [AMT_W-1:0] amt,
  input  logic             start,
  output logic [WIDTH-1:0] o,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_mode;
  logic [AMT_W-1:0] r_count;
  logic [WIDTH-1:0] r_o;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_normalNext;
  logic [WIDTH-1:0] w_burstNext;
  logic             w_startBurst;

  function automatic logic [WIDTH-1:0] applyMode(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (mode)
      3'b001: res = {cur[WIDTH-2:0], sl};
      3'b010: res = {sr, cur[WIDTH-1:1]};
      3'b011: res = ld;
`ifdef SHREG_ROTATE_EN
      3'b100: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101: res = {cur[0], cur[WIDTH-1:1]};
`endif
      3'b110: res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111: res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only modes that move bits may launch a burst.
  function automatic logic isShiftClass(input logic [2:0] mode);
    logic res;
    case (mode)
      3'b001, 3'b010, 3'b110: res = 1'b1;
`ifdef SHREG_ROTATE_EN
      3'b100, 3'b101: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_normalNext = applyMode(s, r_o, i, sl_in, sr_in);
  assign w_burstNext  = applyMode(r_mode, r_o, i, sl_in, sr_in);
  assign w_startBurst = (r_state == ST_IDLE) && start && isShiftClass(s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= 3'b000;
      r_count <= '0;
      r_o     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_startBurst) begin
            r_mode  <= s;
            r_count <= amt;
            if (amt != '0) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_o <= w_normalNext;
          end
        end
        // Serial inputs stay live during a burst; everything else is frozen.
        ST_RUN: begin
          r_o     <= w_burstNext;
          r_count <= r_count - 1'b1;
          if (r_count == AMT_W'(1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_o     <= w_normalNext;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o      = r_o;
  assign so_msb = r_o[WIDTH-1];
  assign so_lsb = r_o[0];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus a randomized run
// checked against a cycle-stamped burst model.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int A = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] i;
  logic [2:0]   s;
  logic         sl_in;
  logic         sr_in;
  logic [A-1:0] amt;
  logic         start;
  logic [W-1:0] o;
  logic         so_msb;
  logic         so_lsb;
  logic         busy;
  logic         done;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: a burst is described by the edge that launched it and its length.
  logic [W-1:0] mO;
  int           edgeNum;
  int           bStart;
  int           bAmt;
  logic [2:0]   bMode;
  logic         expBusy;
  logic         expDone;

  univ_shift_reg #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .reset(reset), .i(i), .s(s), .sl_in(sl_in), .sr_in(sr_in),
    .amt(amt), .start(start), .o(o), .so_msb(so_msb), .so_lsb(so_lsb),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rotOn();
`ifdef SHREG_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic modelShifts(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd6) || (rotOn() && (m == 3'd4 || m == 3'd5));
  endfunction

  function automatic logic [W-1:0] modelOp(input logic [2:0] m, input logic [W-1:0] v,
                                           input logic [W-1:0] ld, input logic sl, input logic sr);
    int x;
    x = int'(v);
    case (m)
      3'd1: x = (x * 2 + int'(sl)) % (1 << W);
      3'd2: x = x / 2 + int'(sr) * (1 << (W - 1));
      3'd3: x = int'(ld);
      3'd4: if (rotOn()) x = (x * 2) % (1 << W) + x / (1 << (W - 1));
      3'd5: if (rotOn()) x = x / 2 + (x % 2) * (1 << (W - 1));
      3'd6: x = x / 2 + (x / (1 << (W - 1))) * (1 << (W - 1));
      3'd7: x = 0;
      default: ;
    endcase
    return W'(x);
  endfunction

  task automatic modelReset();
    mO      = '0;
    bStart  = -1000;
    bAmt    = 0;
    bMode   = 3'd0;
    expBusy = 1'b0;
    expDone = 1'b0;
  endtask

  task automatic modelEdge();
    logic inShift, inDone;
    edgeNum++;
    inShift = (edgeNum > bStart) && (edgeNum <= bStart + bAmt);
    inDone  = (edgeNum == bStart + bAmt + 1);
    if (inShift) mO = modelOp(bMode, mO, i, sl_in, sr_in);
    else if (start && modelShifts(s) && !inDone && !(edgeNum == bStart)) begin
      bStart = edgeNum;
      bAmt   = int'(amt);
      bMode  = s;
    end else mO = modelOp(s, mO, i, sl_in, sr_in);
    expBusy = (edgeNum >= bStart) && (edgeNum < bStart + bAmt);
    expDone = (edgeNum == bStart + bAmt);
  endtask

  task automatic applyStimulus(input logic [2:0] ts, input logic [W-1:0] ti, input logic tsl,
                               input logic tsr, input logic [A-1:0] tamt, input logic tstart);
    s = ts; i = ti; sl_in = tsl; sr_in = tsr; amt = tamt; start = tstart;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    s = 3'd0; i = '0; sl_in = 1'b0; sr_in = 1'b0; amt = '0; start = 1'b0;
    reset = 1'b1;
    modelReset();
    #12;
    nChecks++;
    if (o !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_state: o=%h busy=%b done=%b required o=00 busy=0 done=0", o, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(3'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    nChecks++;
    if (o !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL reset_release_hold: o=%h required 00", o);
    end
  endtask

  task automatic test_modes();
    applyStimulus(3'd3, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
    nChecks++;
    if (o !== 8'hA5) begin nFails++; $display("[TB] FAIL mode_load: o=%h required a5", o); end
    applyStimulus(3'd0, 8'h00, 1'b1, 1'b1, '0, 1'b0);
    nChecks++;
    if (o !== 8'hA5) begin nFails++; $display("[TB] FAIL mode_hold: o=%h required a5", o); end
    applyStimulus(3'd1, 8'h00, 1'b0, 1'b1, '0, 1'b0);
    nChecks++;
    if (o !== 8'h4A) begin nFails++; $display("[TB] FAIL mode_shl: o=%h required 4a", o); end
    applyStimulus(3'd2, 8'h00, 1'b0, 1'b1, '0, 1'b0);
    nChecks++;
    if (o !== 8'hA5) begin nFails++; $display("[TB] FAIL mode_shr: o=%h required a5", o); end
    nChecks++;
    if (so_msb !== 1'b1 || so_lsb !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL serial_taps: msb=%b lsb=%b required 1 1", so_msb, so_lsb);
    end
    applyStimulus(3'd3, 8'h96, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(3'd6, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    nChecks++;
    if (o !== 8'hCB) begin nFails++; $display("[TB] FAIL mode_asr: o=%h required cb", o); end
    applyStimulus(3'd7, 8'hFF, 1'b1, 1'b1, '0, 1'b0);
    nChecks++;
    if (o !== 8'h00) begin nFails++; $display("[TB] FAIL mode_clear: o=%h required 00", o); end
  endtask

  task automatic test_rotate_burst();
    int busyCnt, doneCnt;
    logic [W-1:0] expO;
    busyCnt = 0;
    doneCnt = 0;
    applyStimulus(3'd3, 8'h81, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(3'd4, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1);
    if (busy === 1'b1) busyCnt++;
    if (done === 1'b1) doneCnt++;
    for (int n = 0; n < 5; n++) begin
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) doneCnt++;
      nChecks++;
      if (busy === 1'b1 && done === 1'b1) begin
        nFails++;
        $display("[TB] FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
      end
    end
    expO = rotOn() ? 8'h0C : 8'h81;
    nChecks++;
    if (o !== expO) begin nFails++; $display("[TB] FAIL rotate_burst_o: o=%h required %h", o, expO); end
    nChecks++;
    if (busyCnt != (rotOn() ? 3 : 0)) begin
      nFails++;
      $display("[TB] FAIL rotate_burst_busy: cycles=%0d required %0d", busyCnt, rotOn() ? 3 : 0);
    end
    nChecks++;
    if (doneCnt != (rotOn() ? 1 : 0)) begin
      nFails++;
      $display("[TB] FAIL rotate_burst_done: pulses=%0d required %0d", doneCnt, rotOn() ? 1 : 0);
    end
  endtask

  task automatic test_zero_amt();
    applyStimulus(3'd3, 8'h3C, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(3'd1, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1);
    nChecks++;
    if (o !== 8'h3C || busy !== 1'b0 || done !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL zero_amt_start: o=%h busy=%b done=%b required 3c 0 1", o, busy, done);
    end
    applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    nChecks++;
    if (o !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL zero_amt_after: o=%h busy=%b done=%b required 3c 0 0", o, busy, done);
    end
  endtask

  task automatic test_ignore_midburst();
    int doneCnt;
    doneCnt = 0;
    applyStimulus(3'd3, 8'hFF, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(3'd2, 8'h00, 1'b0, 1'b0, 4'd5, 1'b1);
    for (int n = 0; n < 7; n++) begin
      if (n == 2) applyStimulus(3'd3, 8'h00, 1'b0, 1'b0, 4'd9, 1'b1);
      else        applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
      if (done === 1'b1) doneCnt++;
    end
    nChecks++;
    if (o !== 8'h07) begin nFails++; $display("[TB] FAIL midburst_o: o=%h required 07", o); end
    nChecks++;
    if (doneCnt != 1) begin nFails++; $display("[TB] FAIL midburst_done: pulses=%0d required 1", doneCnt); end
  endtask

  task automatic test_reset_midburst();
    int doneCnt;
    doneCnt = 0;
    applyStimulus(3'd3, 8'h5A, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(3'd1, 8'h00, 1'b1, 1'b0, 4'd8, 1'b1);
    applyStimulus(3'd0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(3'd0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    #1;
    reset = 1'b1;
    modelReset();
    #1;
    nChecks++;
    if (o !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_midburst: o=%h busy=%b done=%b required 00 0 0", o, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(3'd0, 8'h00, 1'b1, 1'b1, '0, 1'b0);
      if (done === 1'b1) doneCnt++;
    end
    nChecks++;
    if (o !== 8'h00 || doneCnt != 0) begin
      nFails++;
      $display("[TB] FAIL post_abort: o=%h done_pulses=%0d required 00 0", o, doneCnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom),
                    A'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0));
      nChecks++;
      if (o !== mO || busy !== expBusy || done !== expDone || so_msb !== mO[W-1] || so_lsb !== mO[0]) begin
        nFails++;
        $display("[TB] FAIL random_%0d: o=%h busy=%b done=%b msb=%b lsb=%b required %h %b %b %b %b",
                 n, o, busy, done, so_msb, so_lsb, mO, expBusy, expDone, mO[W-1], mO[0]);
      end
    end
  endtask

  initial begin
    edgeNum = 0;
    test_reset();
    test_modes();
    test_rotate_burst();
    test_zero_amt();
    test_ignore_midburst();
    test_reset_midburst();
    doReset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the 8-bit 4-mode shifter. Adds a 3-bit mode select, arithmetic shift right, clear, separate left/right serial inputs, serial-out taps, and a counted burst engine that shifts N times autonomously with busy/done status. Used as the general shift/serialiser primitive in lab datapaths.

Parameters:
WIDTH, 8, register width in bits; must be at least 2.
AMT_W, 4, width of burst count input; 2**AMT_W-1 >= WIDTH is required.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
i  input  WIDTH  parallel load data
s  input  3  mode select
sl_in  input  1  serial input shifted into bit 0 on left shift
sr_in  input  1  serial input shifted into bit WIDTH-1 on logical right shift
amt  input  AMT_W  burst shift count
start  input  1  burst request, sampled at clock edge
o  output  WIDTH  register contents (registered)
so_msb  output  1  o[WIDTH-1], combinational tap
so_lsb  output  1  o[0], combinational tap
busy  output  1  high while burst shifting
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-high. While reset=1, all of the following hold immediately, independent of clk: o=0, busy=0, done=0, FSM=IDLE, internal count=0.
- Mode encoding, applied at each rising edge when not bursting:
  - 000: hold.
  - 001: shift left; o <= {o[W-2:0], sl_in}.
  - 010: logical shift right; o <= {sr_in, o[W-1:1]}.
  - 011: parallel load; o <= i.
  - 100: rotate left.
  - 101: rotate right.
  - 110: arithmetic shift right; MSB is replicated.
  - 111: clear; o <= 0.
- Shift-class modes are 001, 010, 100, 101 and 110.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with a shift-class s: latch s into a burst-mode register, latch amt into the count, and leave o unchanged on that edge. Next state is RUN if amt != 0, otherwise DONE.
  - start=1 with a non-shift-class s: start is ignored and s executes normally.
  - start=0: s executes normally.
- RUN:
  - busy=1.
  - Each edge performs one shift using the latched mode; the count is decremented.
  - The edge on which the count goes from 1 to 0 performs the last shift and moves to DONE.
  - sl_in and sr_in are sampled live each cycle.
  - s, i, amt and start are ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - s executes normally during DONE.
  - start is ignored during DONE.
- Burst latency: start at edge k gives amt shifts at edges k+1..k+amt. done is high in the cycle after edge k+amt. For amt=0, done is high in the cycle after edge k.
- Reset asserted mid-burst aborts the burst: o clears and no done pulse is issued.
- busy and done are registered; they are never high together.

Optional Feature:
SHREG_ROTATE_EN: when defined, modes 100 and 101 rotate as specified, both as single ops and in bursts. When undefined, 100 and 101 decode as hold, are not shift-class, and start with them is ignored.

Test Plan:
1. Reset, then s=011 with i=0xA5 → o=0xA5. s=000 → o stays 0xA5. s=001 with sl_in=0 → o=0x4A. s=010 with sr_in=1 → o=0xA5.
2. Load 0x96, then s=110 for one edge → o=0xCB. Then s=111 → o=0x00.
3. Macro on: load 0x81, s=100, amt=3, start pulse → busy high for exactly 3 cycles, then o=0x0C and done high for one cycle. Macro off, same stimulus → o stays 0x81 and busy/done never assert.
4. IDLE, s=001, amt=0, start=1 → o unchanged, busy never asserts, done pulses one cycle after the start edge.
5. Burst s=010 with amt=5 on 0xFF and sr_in=0. Mid-burst, drive start=1, s=011 and i=0x00 → both ignored; final o=0x07 with a single done pulse.
6. Burst in progress, then reset asserted between clock edges → o=0, busy=0 and done=0 immediately. After release, no done pulse occurs and o=0.
